// File: rtl/pipelined_cpu_pkg.sv
// Shared definitions for the 5-stage pipelined CPU: sizes, field positions,
// opcodes, pipeline register layouts and the default instruction ROM image.
package pipelined_cpu_pkg;

  localparam int WIDTH      = 32;
  localparam int IMEM_DEPTH = 16;
  localparam int DMEM_DEPTH = 16;
  localparam int NREGS      = 8;
  localparam int IADDR_W    = $clog2(IMEM_DEPTH);
  localparam int DADDR_W    = $clog2(DMEM_DEPTH);
  localparam int RADDR_W    = 3;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 24;
  localparam int RS1_MSB = 22;
  localparam int RS1_LSB = 20;
  localparam int RS2_MSB = 18;
  localparam int RS2_LSB = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LI  = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_LW  = 4'd4,
    OP_SW  = 4'd5
  } opcode_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [3:0]         op;
    logic [RADDR_W-1:0] rd;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   imm;
  } id_ex_t;

  typedef struct packed {
    logic [3:0]         op;
    logic [RADDR_W-1:0] rd;
    logic [WIDTH-1:0]   alu;
    logic [WIDTH-1:0]   store;
  } ex_mem_t;

  typedef struct packed {
    logic [3:0]         op;
    logic [RADDR_W-1:0] rd;
    logic [WIDTH-1:0]   wdata;
  } mem_wb_t;

  function automatic logic [31:0] encode(opcode_e op, logic [2:0] rd, logic [2:0] rs1,
                                         logic [2:0] rs2, logic [15:0] imm);
    logic [31:0] w;
    w = NOP_INSTR;
    w[OP_MSB:OP_LSB]   = op;
    w[RD_MSB:RD_LSB]   = rd;
    w[RS1_MSB:RS1_LSB] = rs1;
    w[RS2_MSB:RS2_LSB] = rs2;
    w[IMM_MSB:IMM_LSB] = imm;
    return w;
  endfunction

  // Hazard-free by construction: every consumer sits >= 2 slots after its producer.
  function automatic logic [31:0] rom_image(logic [IADDR_W-1:0] addr);
    case (int'(addr))
      0:       return encode(OP_LI,  3'd1, 3'd0, 3'd0, 16'd5);
      1:       return encode(OP_LI,  3'd2, 3'd0, 3'd0, 16'd7);
      4:       return encode(OP_ADD, 3'd3, 3'd1, 3'd2, 16'd0);
      7:       return encode(OP_SW,  3'd0, 3'd0, 3'd3, 16'd0);
      8:       return encode(OP_SW,  3'd0, 3'd0, 3'd1, 16'd1);
      9:       return encode(OP_LW,  3'd2, 3'd0, 3'd0, 16'd0);
      default: return NOP_INSTR;
    endcase
  endfunction

endpackage

// File: rtl/cpu_dmem.sv
// 16-word data memory: synchronous write, combinational read of committed contents.
module cpu_dmem
  import pipelined_cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [DADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata,
  output logic [WIDTH-1:0]   out_reg0,
  output logic [WIDTH-1:0]   out_reg1
);

  logic [DMEM_DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[addr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign rdata    = mem_q[addr];
  assign out_reg0 = mem_q[0];
  assign out_reg1 = mem_q[1];

endmodule

// File: rtl/cpu_regfile.sv
// 8-entry register file, r0 hard-wired to zero, write-through read ports.
module cpu_regfile
  import pipelined_cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [RADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [RADDR_W-1:0] raddr1,
  input  logic [RADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]   rdata1,
  output logic [WIDTH-1:0]   rdata2,
  output logic [WIDTH-1:0]   out_reg1,
  output logic [WIDTH-1:0]   out_reg2,
  output logic [WIDTH-1:0]   out_reg3
);

  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;

  // Reads come from the next-state image so a same-cycle write is visible.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) regs_d[waddr] = wdata;
    rdata1 = (raddr1 == '0) ? '0 : regs_d[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : regs_d[raddr2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  assign out_reg1 = regs_q[1];
  assign out_reg2 = regs_q[2];
  assign out_reg3 = regs_q[3];

endmodule

// File: rtl/cpu_step_1.sv
// Fetch stage: program counter and instruction ROM lookup.
module cpu_step_1
  import pipelined_cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic [IADDR_W-1:0] pc_out,
  output logic [31:0]        instr_out
);

  logic [IADDR_W-1:0] pc_q, pc_d;

  // PC is exactly IADDR_W bits wide, so the increment wraps at IMEM_DEPTH.
  always_comb pc_d = pc_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign pc_out    = pc_q;
  assign instr_out = rom_image(pc_q);

endmodule

// File: rtl/cpu_step_2.sv
// Decode stage: holds the fetched instruction and reads operands from the register file.
module cpu_step_2
  import pipelined_cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr_in,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]   wb_data,
  output id_ex_t             dec_out,
  output logic [3:0]         opcode_step_2,
  output logic [WIDTH-1:0]   out_reg1,
  output logic [WIDTH-1:0]   out_reg2,
  output logic [WIDTH-1:0]   out_reg3
);

  logic [31:0]      instr_q, instr_d;
  logic [WIDTH-1:0] rdata1, rdata2;

  always_comb instr_d = instr_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) instr_q <= NOP_INSTR;
    else     instr_q <= instr_d;
  end

  cpu_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_we),
    .waddr    (wb_addr),
    .wdata    (wb_data),
    .raddr1   (instr_q[RS1_MSB:RS1_LSB]),
    .raddr2   (instr_q[RS2_MSB:RS2_LSB]),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .out_reg1 (out_reg1),
    .out_reg2 (out_reg2),
    .out_reg3 (out_reg3)
  );

  always_comb begin
    dec_out     = '0;
    dec_out.op  = instr_q[OP_MSB:OP_LSB];
    dec_out.rd  = instr_q[RD_MSB:RD_LSB];
    dec_out.a   = rdata1;
    dec_out.b   = rdata2;
    dec_out.imm = {{(WIDTH-16){instr_q[IMM_MSB]}}, instr_q[IMM_MSB:IMM_LSB]};
  end

  assign opcode_step_2 = instr_q[OP_MSB:OP_LSB];

endmodule

// File: rtl/cpu_step_3.sv
// Execute stage: ALU computes the result or the effective memory address.
module cpu_step_3
  import pipelined_cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  id_ex_t     dec_in,
  output ex_mem_t    exe_out,
  output logic [3:0] opcode_step_3
);

  id_ex_t id_ex_q, id_ex_d;

  always_comb id_ex_d = dec_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  always_comb begin
    exe_out       = '0;
    exe_out.op    = id_ex_q.op;
    exe_out.rd    = id_ex_q.rd;
    exe_out.store = id_ex_q.b;
    case (id_ex_q.op)
      OP_LI:        exe_out.alu = id_ex_q.imm;
      OP_ADD:       exe_out.alu = id_ex_q.a + id_ex_q.b;
      OP_SUB:       exe_out.alu = id_ex_q.a - id_ex_q.b;
      OP_LW, OP_SW: exe_out.alu = id_ex_q.a + id_ex_q.imm;
      default:      exe_out.alu = '0;
    endcase
  end

  assign opcode_step_3 = id_ex_q.op;

endmodule

// File: rtl/cpu_step_4.sv
// Memory stage: stores commit on the clock edge, loads read the committed contents.
module cpu_step_4
  import pipelined_cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  ex_mem_t          exe_in,
  output mem_wb_t          mem_out,
  output logic [3:0]       opcode_step_4,
  output logic [WIDTH-1:0] mem_out0,
  output logic [WIDTH-1:0] mem_out1
);

  ex_mem_t          ex_mem_q, ex_mem_d;
  logic [WIDTH-1:0] load_data;

  always_comb ex_mem_d = exe_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_mem_q <= '0;
    else     ex_mem_q <= ex_mem_d;
  end

  cpu_dmem u_dmem (
    .clk      (clk),
    .rst      (rst),
    .we       (ex_mem_q.op == OP_SW),
    .addr     (ex_mem_q.alu[DADDR_W-1:0]),
    .wdata    (ex_mem_q.store),
    .rdata    (load_data),
    .out_reg0 (mem_out0),
    .out_reg1 (mem_out1)
  );

  always_comb begin
    mem_out       = '0;
    mem_out.op    = ex_mem_q.op;
    mem_out.rd    = ex_mem_q.rd;
    mem_out.wdata = (ex_mem_q.op == OP_LW) ? load_data : ex_mem_q.alu;
  end

  assign opcode_step_4 = ex_mem_q.op;

endmodule

// File: rtl/cpu_step_5.sv
// Write-back stage: selects which instructions update the register file.
module cpu_step_5
  import pipelined_cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  mem_wb_t            mem_in,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [WIDTH-1:0]   wb_data,
  output logic [3:0]         opcode_step_5
);

  mem_wb_t mem_wb_q, mem_wb_d;

  always_comb mem_wb_d = mem_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_wb_q <= '0;
    else     mem_wb_q <= mem_wb_d;
  end

  always_comb begin
    wb_we   = 1'b0;
    wb_addr = mem_wb_q.rd;
    wb_data = mem_wb_q.wdata;
    case (mem_wb_q.op)
      OP_LI, OP_ADD, OP_SUB, OP_LW: wb_we = 1'b1;
      default:                      wb_we = 1'b0;
    endcase
  end

  assign opcode_step_5 = mem_wb_q.op;

endmodule

// File: rtl/pipelined_cpu.sv
// Top of the 5-stage in-order CPU; observation signals are reached hierarchically.
module pipelined_cpu
  import pipelined_cpu_pkg::*;
(
  input logic clk,
  input logic rst
);

  logic [IADDR_W-1:0] pc_out;
  logic [31:0]        fetch_instr;
  id_ex_t             dec;
  ex_mem_t            exe;
  mem_wb_t            memr;
  logic               wb_we;
  logic [RADDR_W-1:0] wb_addr;
  logic [WIDTH-1:0]   wb_data;
  logic [3:0]         opcode_step_2, opcode_step_3, opcode_step_4, opcode_step_5;
  logic [WIDTH-1:0]   out_reg1, out_reg2, out_reg3, mem_out0, mem_out1;

  cpu_step_1 u_step1 (
    .clk       (clk),
    .rst       (rst),
    .pc_out    (pc_out),
    .instr_out (fetch_instr)
  );

  cpu_step_2 u_step2 (
    .clk           (clk),
    .rst           (rst),
    .instr_in      (fetch_instr),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .dec_out       (dec),
    .opcode_step_2 (opcode_step_2),
    .out_reg1      (out_reg1),
    .out_reg2      (out_reg2),
    .out_reg3      (out_reg3)
  );

  cpu_step_3 u_step3 (
    .clk           (clk),
    .rst           (rst),
    .dec_in        (dec),
    .exe_out       (exe),
    .opcode_step_3 (opcode_step_3)
  );

  cpu_step_4 u_step4 (
    .clk           (clk),
    .rst           (rst),
    .exe_in        (exe),
    .mem_out       (memr),
    .opcode_step_4 (opcode_step_4),
    .mem_out0      (mem_out0),
    .mem_out1      (mem_out1)
  );

  cpu_step_5 u_step5 (
    .clk           (clk),
    .rst           (rst),
    .mem_in        (memr),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .opcode_step_5 (opcode_step_5)
  );

endmodule

// File: tb/tb_pipelined_cpu.sv
// Directed bench for pipelined_cpu: expectations are queued per clock edge and
// compared against hierarchically observed state after each edge.
module tb_pipelined_cpu;

  logic clk;
  logic rst;

  pipelined_cpu dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    OBS_PC, OBS_R1, OBS_R2, OBS_R3, OBS_M0, OBS_M1,
    OBS_OP2, OBS_OP3, OBS_OP4, OBS_OP5
  } obs_e;

  typedef struct {
    int          edge_n;
    obs_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   check_count = 0;
  int   pass_count  = 0;
  int   fail_count  = 0;

  function automatic logic [31:0] observe(obs_e sel);
    case (sel)
      OBS_PC:  return 32'(dut.pc_out);
      OBS_R1:  return dut.out_reg1;
      OBS_R2:  return dut.out_reg2;
      OBS_R3:  return dut.out_reg3;
      OBS_M0:  return dut.mem_out0;
      OBS_M1:  return dut.mem_out1;
      OBS_OP2: return 32'(dut.opcode_step_2);
      OBS_OP3: return 32'(dut.opcode_step_3);
      OBS_OP4: return 32'(dut.opcode_step_4);
      default: return 32'(dut.opcode_step_5);
    endcase
  endfunction

  task automatic push_exp(input int n, input obs_e sel, input logic [31:0] v);
    exp_t e;
    e.edge_n = n;
    e.sel    = sel;
    e.val    = v;
    exp_q.push_back(e);
  endtask

  task automatic push_reset_exp();
    for (int s = 0; s < 10; s++) push_exp(0, obs_e'(s), 32'd0);
  endtask

  // Expected architectural state after edge n of the default program.
  task automatic push_edge_exp(input int n);
    case (n)
      1:  begin push_exp(n, OBS_PC, 1); push_exp(n, OBS_OP2, 1); end
      2:  begin push_exp(n, OBS_PC, 2); push_exp(n, OBS_OP2, 1); push_exp(n, OBS_OP3, 1); end
      3:  begin push_exp(n, OBS_PC, 3); push_exp(n, OBS_OP2, 0); push_exp(n, OBS_OP4, 1); end
      4:  begin push_exp(n, OBS_PC, 4); push_exp(n, OBS_OP2, 0); push_exp(n, OBS_OP5, 1);
                push_exp(n, OBS_R1, 0); end
      5:  begin push_exp(n, OBS_PC, 5); push_exp(n, OBS_R1, 5); push_exp(n, OBS_R2, 0); end
      6:  begin push_exp(n, OBS_R2, 7); push_exp(n, OBS_R3, 0); end
      8:  push_exp(n, OBS_R3, 0);
      9:  push_exp(n, OBS_R3, 12);
      10: push_exp(n, OBS_M0, 0);
      11: begin push_exp(n, OBS_M0, 12); push_exp(n, OBS_M1, 0); end
      12: push_exp(n, OBS_M1, 5);
      13: push_exp(n, OBS_R2, 7);
      14: push_exp(n, OBS_R2, 12);
      15: begin push_exp(n, OBS_PC, 15); push_exp(n, OBS_OP2, 0); push_exp(n, OBS_OP3, 0);
                push_exp(n, OBS_OP4, 0); push_exp(n, OBS_OP5, 0);
                push_exp(n, OBS_R1, 5); push_exp(n, OBS_R3, 12); end
      16: push_exp(n, OBS_PC, 0);
      default: ;
    endcase
  endtask

  task automatic check_output(input int n);
    exp_t        e;
    logic [31:0] obs;
    while (exp_q.size() > 0 && exp_q[0].edge_n == n) begin
      e   = exp_q.pop_front();
      obs = observe(e.sel);
      check_count++;
      assert (obs === e.val) pass_count++;
      else begin
        fail_count++;
        $error("[TB] FAIL %s@edge%0d observed=%0d expected=%0d", e.sel.name(), n, obs, e.val);
      end
    end
  endtask

  task automatic apply_stimulus(input int n);
    push_edge_exp(n);
    @(posedge clk);
    #2;
    check_output(n);
  endtask

  initial begin
    #10000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    #7;
    push_reset_exp();
    check_output(0);
    #3 rst = 1'b0;

    for (int n = 1; n <= 6; n++) apply_stimulus(n);

    #5 rst = 1'b1;
    #1;
    $display("[TB] reset asserted mid-run at %0t", $time);
    push_reset_exp();
    check_output(0);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 1; n <= 16; n++) apply_stimulus(n);

    check_count++;
    assert (exp_q.size() == 0) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
